// File: rtl/div_req_sched.sv
// ---------------------------------------------------------------------------
// div_req_sched
//
// Request scheduler that sits directly upstream of the fixed-point divider in
// the RX path. It accepts signed (a, b, tag) division requests, buffers them
// in a small FIFO, and runs the divider's start/done handshake one operation
// at a time. Tagged quotients come back through a single-entry output slot.
//
// Divide-by-zero requests never reach the divider, which has no dbz handling.
// The scheduler resolves them locally to a saturated quotient whose sign
// follows the dividend: +max for a>0, -max (0x8001 at 16 bits) for a<0, and 0
// for a==0.
//
// Parameters:
//   WIDTH  operand/result width (signed, two's complement)
//   FBITS  fractional bits (must match the divider instance)
//   DEPTH  request FIFO depth (power of two, >= 2)
//   TAG_W  width of the tag carried through to the result
//
// Ports:
//   clk, i_rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready               request handshake (in_ready is registered)
//   in_a, in_b, in_tag              dividend, divisor, tag
//   div_start                       one-cycle start pulse to the divider
//   div_a, div_b                    operands to the divider, held until done
//   div_done, div_val               divider completion pulse and quotient
//   out_valid/out_ready             result handshake
//   out_q, out_tag, out_dbz         quotient, tag, divide-by-zero flag
//
// Optional feature (macro DIV_SCHED_CNT_EN):
//   cnt_div  count of results captured from the divider (saturates at 0xFFFF)
//   cnt_dbz  count of requests resolved locally as b==0 (saturates at 0xFFFF)
// ---------------------------------------------------------------------------
module div_req_sched #(
    parameter int WIDTH = 16,
    parameter int FBITS = 12,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [TAG_W-1:0] out_tag,
`ifdef DIV_SCHED_CNT_EN
    output logic [15:0]      cnt_div,
    output logic [15:0]      cnt_dbz,
`endif
    output logic             out_dbz
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Divide-by-zero results: saturate toward the sign of the dividend.
    localparam logic [WIDTH-1:0] Q_POS_SAT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_NEG_SAT = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

    // Reject parameter sets that the pointer arithmetic or the divider
    // cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("div_req_sched: DEPTH must be a power of two >= 2");
    end
    if (FBITS < 0 || FBITS >= WIDTH) begin : g_bad_fbits
        $error("div_req_sched: FBITS must lie in [0, WIDTH)");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_a   [DEPTH];
    logic [WIDTH-1:0] mem_b   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [TAG_W-1:0] head_tag;
    logic [WIDTH-1:0] dbz_q;

    assign push       = in_valid && in_ready;
    assign fifo_empty = (count == '0);
    assign head_a     = mem_a[rd_ptr];
    assign head_b     = mem_b[rd_ptr];
    assign head_tag   = mem_tag[rd_ptr];

    // An entry leaves the FIFO either when it is resolved locally as a
    // divide-by-zero or when the divider reports completion for it. The
    // head stays in place during ISSUE/WAIT so its tag is still available
    // when the quotient returns.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty && !out_valid && (head_b == '0);
            WAIT:    pop = div_done;
            default: pop = 1'b0;
        endcase
    end

    always_comb begin
        count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end

    always_comb begin
        if (head_a[WIDTH-1]) begin
            dbz_q = Q_NEG_SAT;
        end else if (head_a != '0) begin
            dbz_q = Q_POS_SAT;
        end else begin
            dbz_q = '0;
        end
    end

    // Storage needs no reset; the pointers and the count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    // in_ready is taken from the next-cycle count, so the upstream sees no
    // combinational path from the pop logic.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            in_ready <= (count_next < DEPTH_C);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and output slot
    // ------------------------------------------------------------------
    // A new request is taken from the head only while the output slot is
    // empty. That keeps exactly one result in flight and guarantees that
    // the slot is free when div_done arrives.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_tag   <= '0;
            out_dbz   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty && !out_valid) begin
                        if (head_b == '0) begin
                            out_valid <= 1'b1;
                            out_q     <= dbz_q;
                            out_tag   <= head_tag;
                            out_dbz   <= 1'b1;
                        end else begin
                            div_a     <= head_a;
                            div_b     <= head_b;
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    div_start <= 1'b0;
                    state     <= WAIT;
                end

                WAIT: begin
                    if (div_done) begin
                        out_valid <= 1'b1;
                        out_q     <= div_val;
                        out_tag   <= head_tag;
                        out_dbz   <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    div_start <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef DIV_SCHED_CNT_EN
    // Saturating event counters for results from the divider and for
    // locally resolved divide-by-zero requests.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            cnt_div <= '0;
            cnt_dbz <= '0;
        end else begin
            if (state == WAIT && div_done && cnt_div != 16'hFFFF) begin
                cnt_div <= cnt_div + 16'd1;
            end
            if (state == IDLE && pop && cnt_dbz != 16'hFFFF) begin
                cnt_dbz <= cnt_dbz + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_req_sched.sv
// ---------------------------------------------------------------------------
// tb_div_req_sched
//
// Directed bench for div_req_sched. A small behavioural divider with three
// cycles of latency and a Q4.12 quotient stands in for the real divider. It
// returns 0 on overflow and drives garbage on div_val when not done. All
// expected quotients are hand-computed constants.
//
// Scenarios: reset values, a single request, signed requests, divide-by-zero,
// backpressure with a full FIFO, a mixed stream with random out_ready, and a
// reset during a division.
//
// When built with DIV_SCHED_CNT_EN, the bench also checks the counter ports.
// ---------------------------------------------------------------------------
module tb_div_req_sched;

    localparam int WIDTH = 16;
    localparam int FBITS = 12;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk;
    logic             i_rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             div_start;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_done;
    logic [WIDTH-1:0] div_val;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [TAG_W-1:0] out_tag;
    logic             out_dbz;
`ifdef DIV_SCHED_CNT_EN
    logic [15:0]      cnt_div;
    logic [15:0]      cnt_dbz;
`endif

    div_req_sched #(
        .WIDTH(WIDTH),
        .FBITS(FBITS),
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
    ) dut (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_tag   (in_tag),
        .div_start(div_start),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_done (div_done),
        .div_val  (div_val),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_q    (out_q),
        .out_tag  (out_tag),
`ifdef DIV_SCHED_CNT_EN
        .cnt_div  (cnt_div),
        .cnt_dbz  (cnt_dbz),
`endif
        .out_dbz  (out_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;
    int startCount = 0;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [TAG_W-1:0] tag;
        logic             dbz;
    } res_t;

    res_t resQ[$];

    // Hand-computed vectors: backpressure set (tags 0..5).
    logic [15:0] bpA [6] = '{16'h1000, 16'hF000, 16'hF000, 16'h3000, 16'h7000, 16'h0800};
    logic [15:0] bpB [6] = '{16'h2000, 16'h4000, 16'hF000, 16'h1000, 16'h0800, 16'h1000};
    logic [15:0] bpQ [6] = '{16'h0800, 16'hFC00, 16'h1000, 16'h3000, 16'h0000, 16'h0800};

    // Mixed stream: even tags divide by zero, odd tags go to the divider.
    logic [15:0] mxA [8] = '{16'h1800, 16'h1000, 16'h8800, 16'hF000,
                             16'h0000, 16'hF000, 16'h0001, 16'h3000};
    logic [15:0] mxB [8] = '{16'h0000, 16'h2000, 16'h0000, 16'h4000,
                             16'h0000, 16'hF000, 16'h0000, 16'h1000};
    logic [15:0] mxQ [8] = '{16'h7FFF, 16'h0800, 16'h8001, 16'hFC00,
                             16'h0000, 16'h1000, 16'h7FFF, 16'h3000};
    logic        mxD [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    // Behavioural divider: Q(WIDTH-FBITS).FBITS signed quotient, 0 on overflow.
    function automatic logic [15:0] refDivide(input logic [15:0] a, input logic [15:0] b);
        longint num;
        longint den;
        longint q;
        num = longint'($signed(a)) <<< FBITS;
        den = longint'($signed(b));
        if (den == 0) return 16'h0000;
        q = num / den;
        if (q > 32767 || q < -32768) return 16'h0000;
        return q[15:0];
    endfunction

    logic        modelBusy;
    int          modelCnt;
    logic [15:0] modelRes;

    always @(posedge clk) begin
        if (!i_rst_n) begin
            modelBusy <= 1'b0;
            modelCnt  <= 0;
            modelRes  <= '0;
            div_done  <= 1'b0;
            div_val   <= 16'hDEAD;
        end else begin
            div_done <= 1'b0;
            div_val  <= 16'hDEAD;
            if (modelBusy) begin
                if (modelCnt == 1) begin
                    div_done  <= 1'b1;
                    div_val   <= modelRes;
                    modelBusy <= 1'b0;
                end else begin
                    modelCnt <= modelCnt - 1;
                end
            end
            if (div_start && !modelBusy) begin
                modelBusy <= 1'b1;
                modelCnt  <= 3;
                modelRes  <= refDivide(div_a, div_b);
            end
        end
    end

    // Monitor on the falling edge: count start pulses, check that a held
    // result stays stable, and collect accepted results.
    logic             holdValid = 1'b0;
    logic [WIDTH-1:0] holdQ;
    logic [TAG_W-1:0] holdTag;
    logic             holdDbz;

    always @(negedge clk) begin
        if (i_rst_n) begin
            if (div_start) begin
                startCount++;
                if (modelBusy) checkOutput("restart_busy", 32'd1, 32'd0);
            end
            if (holdValid && out_valid) begin
                checkOutput("hold_q", out_q, holdQ);
                checkOutput("hold_tag", out_tag, holdTag);
                checkOutput("hold_dbz", out_dbz, holdDbz);
            end
            holdValid = out_valid && !out_ready;
            holdQ     = out_q;
            holdTag   = out_tag;
            holdDbz   = out_dbz;
            if (out_valid && out_ready) resQ.push_back({out_q, out_tag, out_dbz});
        end else begin
            holdValid = 1'b0;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance or timeout.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] tag, input int maxCycles,
                                 output bit ok);
        bit acc;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int c = 0; c < maxCycles && !ok; c++) begin
            @(negedge clk);
            acc = in_ready;
            stepCycle();
            ok = acc;
        end
        in_valid = 1'b0;
    endtask

    task automatic pushOrFail(input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] tag);
        bit ok;
        applyStimulus(a, b, tag, 100, ok);
        if (!ok) checkOutput("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitResults(input int n, input int budget);
        int c;
        c = 0;
        while (resQ.size() < n && c < budget) begin
            stepCycle();
            c++;
        end
        if (resQ.size() < n) checkOutput("result_timeout", resQ.size(), n);
    endtask

    task automatic checkResult(input string name, input int idx, input logic [15:0] q,
                               input logic [3:0] tag, input logic dbz);
        if (idx < resQ.size()) begin
            checkOutput({name, "_q"}, resQ[idx].q, q);
            checkOutput({name, "_tag"}, resQ[idx].tag, tag);
            checkOutput({name, "_dbz"}, resQ[idx].dbz, dbz);
        end else begin
            checkOutput({name, "_missing"}, resQ.size(), idx + 1);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_in_ready"}, in_ready, 1);
        checkOutput({name, "_div_start"}, div_start, 0);
        checkOutput({name, "_div_a"}, div_a, 0);
        checkOutput({name, "_div_b"}, div_b, 0);
        checkOutput({name, "_out_valid"}, out_valid, 0);
        checkOutput({name, "_out_q"}, out_q, 0);
        checkOutput({name, "_out_tag"}, out_tag, 0);
        checkOutput({name, "_out_dbz"}, out_dbz, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s0;
        int accepted;
        bit ok;

        i_rst_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) stepCycle();
        i_rst_n = 1'b1;
        @(negedge clk);
        checkResetOutputs("reset");
        stepCycle();

        // Single request: 0.5 / ... 1.0/2.0 = 0.5
        out_ready = 1'b1;
        resQ.delete();
        s0 = startCount;
        pushOrFail(16'h1000, 16'h2000, 4'd3);
        waitResults(1, 50);
        checkResult("single", 0, 16'h0800, 4'd3, 1'b0);
        checkOutput("single_starts", startCount - s0, 1);

        // Signed requests
        resQ.delete();
        pushOrFail(16'hF000, 16'h4000, 4'd1);
        pushOrFail(16'hF000, 16'hF000, 4'd2);
        waitResults(2, 80);
        checkResult("signed0", 0, 16'hFC00, 4'd1, 1'b0);
        checkResult("signed1", 1, 16'h1000, 4'd2, 1'b0);

        // Divide by zero resolved locally within two cycles
        s0 = startCount;
        resQ.delete();
        pushOrFail(16'h1800, 16'h0000, 4'd4);
        waitResults(1, 2);
        pushOrFail(16'h8800, 16'h0000, 4'd5);
        waitResults(2, 2);
        pushOrFail(16'h0000, 16'h0000, 4'd6);
        waitResults(3, 2);
        checkResult("dbz_pos", 0, 16'h7FFF, 4'd4, 1'b1);
        checkResult("dbz_neg", 1, 16'h8001, 4'd5, 1'b1);
        checkResult("dbz_zero", 2, 16'h0000, 4'd6, 1'b1);
        checkOutput("dbz_starts", startCount - s0, 0);

        // Backpressure: one division completes, then the FIFO fills.
        out_ready = 1'b0;
        resQ.delete();
        s0 = startCount;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(bpA[i], bpB[i], 4'(i), 20, ok);
            if (ok) accepted++;
        end
        @(negedge clk);
        checkOutput("bp_accepted", accepted, 5);
        checkOutput("bp_in_ready", in_ready, 0);
        checkOutput("bp_starts", startCount - s0, 1);
        checkOutput("bp_out_valid", out_valid, 1);
        checkOutput("bp_out_tag", out_tag, 0);
        stepCycle();
        out_ready = 1'b1;
        applyStimulus(bpA[5], bpB[5], 4'd5, 50, ok);
        checkOutput("bp_push5", ok, 1);
        waitResults(6, 200);
        for (int i = 0; i < 6; i++) begin
            checkResult("bp", i, bpQ[i], 4'(i), 1'b0);
        end

        // Mixed stream with random backpressure
        resQ.delete();
        s0 = startCount;
        fork
            begin
                for (int i = 0; i < 8; i++) pushOrFail(mxA[i], mxB[i], 4'(i));
            end
            begin
                for (int c = 0; c < 400 && resQ.size() < 8; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    stepCycle();
                end
            end
        join
        out_ready = 1'b1;
        waitResults(8, 100);
        for (int i = 0; i < 8; i++) begin
            checkResult("mix", i, mxQ[i], 4'(i), mxD[i]);
        end
        checkOutput("mix_starts", startCount - s0, 4);

        // Reset while a division is in flight with another request queued
        s0 = startCount;
        pushOrFail(16'h1000, 16'h2000, 4'd7);
        pushOrFail(16'h3000, 16'h1000, 4'd8);
        for (int c = 0; c < 20 && startCount == s0; c++) stepCycle();
        checkOutput("rst_started", startCount - s0, 1);
        stepCycle();
        i_rst_n = 1'b0;
        stepCycle();
        i_rst_n = 1'b1;
        @(negedge clk);
        checkResetOutputs("midrst");
        stepCycle();
        resQ.delete();
        s0 = startCount;
        repeat (15) stepCycle();
        checkOutput("midrst_starts", startCount - s0, 0);
        checkOutput("midrst_results", resQ.size(), 0);
        pushOrFail(16'h3000, 16'h1000, 4'd9);
        waitResults(1, 50);
        checkResult("after_rst", 0, 16'h3000, 4'd9, 1'b0);
        checkOutput("after_rst_starts", startCount - s0, 1);

`ifdef DIV_SCHED_CNT_EN
        @(negedge clk);
        checkOutput("cnt_div", cnt_div, 1);
        checkOutput("cnt_dbz", cnt_dbz, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
